sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Single-clock, parametrised successor to the team's asynchronous FIFO, for buffering inside one clock domain.
- Adds programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Depth is 2^FIFO_DEPTH_WIDTH words.
- Port names match the asynchronous FIFO so the two are interchangeable at block level.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- FIFO_DEPTH_WIDTH, 5, log2 of depth; D = 2^FIFO_DEPTH_WIDTH (32 by default).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AFULL_THRESH, 28, almost_full asserts when data_count >= this value; legal range 1..D.
- AEMPTY_THRESH, 4, almost_empty asserts when data_count <= this value; legal range 0..D-1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr  input  1  write request.
- rd  input  1  read request.
- in_data  input  DATA_WIDTH  write data, sampled with wr.
- flush  input  1  synchronous empty-the-FIFO command.
- clr_err  input  1  clears overflow and underflow.
- out_data  output  DATA_WIDTH  read data.
- full  output  1  count == D.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- data_count  output  FIFO_DEPTH_WIDTH+1  words stored, range 0..D.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (asynchronous, rst_n=0) takes effect immediately:
  - pointers = 0, data_count = 0, out_data = 0;
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0;
  - overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words.
- Pointers are FIFO_DEPTH_WIDTH+1 bits; the address is the low FIFO_DEPTH_WIDTH bits. Pointers wrap modulo 2D. full/empty come from the registered data_count.
- Write acceptance: wr && !full. The word is stored at wr_ptr and wr_ptr increments.
- Read acceptance: rd && !empty. rd_ptr increments.
- Full and empty are evaluated on the current-cycle state:
  - wr && rd while full: read accepted, write rejected.
  - wr && rd while empty: write accepted, read rejected.
  - wr && rd with 0 < count < D: both accepted, count unchanged.
- data_count: +1 on write only, -1 on read only, unchanged otherwise. Updates the cycle after the accepting edge. Flags derive combinationally from the registered data_count, so they change in the same cycle as the count.
- FWFT=0 (standard mode):
  - out_data is registered and shows mem[rd_ptr] one cycle after the accepted read edge.
  - Otherwise it holds its last value.
  - Read latency is 1.
- FWFT=1 (FWFT mode):
  - out_data = mem[rd_ptr] whenever !empty. rd acts as acknowledge.
  - The first word is visible the cycle after the write edge, together with empty falling.
  - out_data is don't-care while empty.
- Error flags:
  - overflow sets on wr && full; underflow sets on rd && empty.
  - Both stay set until clr_err. If set and clr_err occur in the same cycle, set wins.
- flush: on the edge where flush=1:
  - pointers and count go to 0;
  - wr and rd in that cycle are ignored and raise no error flags;
  - overflow and underflow are unchanged.
- Threshold and width rules: data_count is FIFO_DEPTH_WIDTH+1 bits so that D is representable. The almost_full and almost_empty comparisons are unsigned.

Decomposition:
- Package fifo_pkg holds:
  - default-width constants (DATA_WIDTH, FIFO_DEPTH_WIDTH);
  - the FWFT/standard mode encoding (MODE_STD=0, MODE_FWFT=1);
  - a threshold-range check function, shared with the asynchronous FIFO.
- One sub-module, fifo_dp_mem: a D x DATA_WIDTH dual-port RAM with synchronous write and combinational read. The top adds the output register for FWFT=0.
- Pointer, count and flag logic stay in the top module.

Test Plan:
Default parameters (D=32, AFULL_THRESH=28, AEMPTY_THRESH=4) unless stated.
1. Reset, then write 0..40 on consecutive cycles.
   - full rises after the 32nd write, data_count = 32.
   - Words 32..40 are dropped; overflow = 1.
   - almost_full rose when data_count reached 28.
2. From full, read 41 cycles with FWFT=0.
   - out_data sequence is 0..31, each one cycle after its read.
   - empty = 1 after the 32nd read; underflow = 1.
   - almost_empty rose when data_count reached 4.
3. FWFT=1, write 0xA5 into an empty FIFO, no rd.
   - The next cycle: empty = 0 and out_data = 0xA5 with no read.
   - Assert rd: empty returns to 1, data_count = 0.
4. Wrap-around with simultaneous traffic: hold rd = 1 and write 0..50 on consecutive cycles.
   - Every word 0..50 is read out in order.
   - data_count never exceeds 1; overflow stays 0.
5. Write 10 words, then assert flush together with wr=1 and rd=1 in the same cycle.
   - data_count = 0 and empty = 1 the next cycle; no error flag set.
   - A subsequent write of 0x3C is the next word read.
6. Set overflow, then pulse clr_err together with a new wr while full.
   - overflow stays 1 (set wins).
   - A later clr_err alone clears it to 0.
   - Finally assert rst_n = 0 mid-write: all outputs take their reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and parameter checks for the synchronous and asynchronous FIFOs.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH       = 8;
    localparam int unsigned DEF_FIFO_DEPTH_WIDTH = 5;

    localparam int unsigned MODE_STD  = 0;
    localparam int unsigned MODE_FWFT = 1;

    // Legal: 1 <= afull <= depth and aempty <= depth-1.
    function automatic bit thresh_ok(input int unsigned depth_width,
                                     input int unsigned afull,
                                     input int unsigned aempty);
        int unsigned depth;
        depth = 32'd1 << depth_width;
        return (afull >= 1) && (afull <= depth) && (aempty < depth);
    endfunction

endpackage

// File: rtl/fifo_dp_mem.sv
// Dual-port storage array: synchronous write, combinational read.
module fifo_dp_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with programmable almost flags, sticky error flags,
// synchronous flush and optional first-word-fall-through read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH_WIDTH = DEF_FIFO_DEPTH_WIDTH,
    parameter int unsigned FWFT             = MODE_STD,
    parameter int unsigned AFULL_THRESH     = 28,
    parameter int unsigned AEMPTY_THRESH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr,
    input  logic                      rd,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      flush,
    input  logic                      clr_err,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [FIFO_DEPTH_WIDTH:0] data_count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned AW    = FIFO_DEPTH_WIDTH;
    localparam int unsigned PW    = FIFO_DEPTH_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_WIDTH;

    if (!thresh_ok(FIFO_DEPTH_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_flags: almost-full/almost-empty threshold out of range");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come straight from the registered count.
    assign full         = (data_count == PW'(DEPTH));
    assign empty        = (data_count == '0);
    assign almost_full  = (data_count >= PW'(AFULL_THRESH));
    assign almost_empty = (data_count <= PW'(AEMPTY_THRESH));

    assign wr_acc = wr && !full  && !flush;
    assign rd_acc = rd && !empty && !flush;

    fifo_dp_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Pointers and occupancy; flush overrides any same-cycle traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   data_count <= data_count + PW'(1);
                2'b01:   data_count <= data_count - PW'(1);
                default: data_count <= data_count;
            endcase
        end
    end

    // Sticky errors: a new event outranks a same-cycle clear; flush neither sets nor clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr && full  && !flush) || (overflow  && !clr_err);
            underflow <= (rd && empty && !flush) || (underflow && !clr_err);
        end
    end

    if (FWFT == MODE_FWFT) begin : g_fwft
        assign out_data = empty ? '0 : mem_rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] out_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
            end else if (rd_acc) begin
                out_q <= mem_rdata;
            end
        end

        assign out_data = out_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: standard-mode and FWFT instances share stimulus.
module tb_sync_fifo_flags;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;
    localparam int NV = 82;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr, rd, flush, clr_err;
    logic [DW-1:0] in_data;

    logic [DW-1:0] s_out, f_out;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [AW:0]   s_cnt, f_cnt;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW), .FWFT(0),
                      .AFULL_THRESH(28), .AEMPTY_THRESH(4)) u_std (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .in_data(in_data),
        .flush(flush), .clr_err(clr_err), .out_data(s_out), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .data_count(s_cnt), .overflow(s_ovf), .underflow(s_udf));

    sync_fifo_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW), .FWFT(1),
                      .AFULL_THRESH(28), .AEMPTY_THRESH(4)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .in_data(in_data),
        .flush(flush), .clr_err(clr_err), .out_data(f_out), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .data_count(f_cnt), .overflow(f_ovf), .underflow(f_udf));

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        logic [AW:0]   cnt;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          ovf;
        logic          udf;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs [NV];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One active edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pack_std();
        return {12'd0, s_cnt, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_out};
    endfunction

    initial begin
        int c;
        // Fill phase: 41 consecutive writes of 0..40.
        for (int i = 0; i < 41; i++) begin
            c = (i + 1 > 32) ? 32 : i + 1;
            vecs[i].wr    = 1'b1;
            vecs[i].rd    = 1'b0;
            vecs[i].din   = DW'(i);
            vecs[i].cnt   = (AW+1)'(c);
            vecs[i].full  = (c == 32);
            vecs[i].empty = 1'b0;
            vecs[i].af    = (c >= 28);
            vecs[i].ae    = (c <= 4);
            vecs[i].ovf   = (i >= 32);
            vecs[i].udf   = 1'b0;
            vecs[i].dout  = '0;
        end
        // Drain phase: 41 consecutive reads.
        for (int j = 0; j < 41; j++) begin
            c = (j >= 31) ? 0 : 31 - j;
            vecs[41+j].wr    = 1'b0;
            vecs[41+j].rd    = 1'b1;
            vecs[41+j].din   = '0;
            vecs[41+j].cnt   = (AW+1)'(c);
            vecs[41+j].full  = 1'b0;
            vecs[41+j].empty = (c == 0);
            vecs[41+j].af    = (c >= 28);
            vecs[41+j].ae    = (c <= 4);
            vecs[41+j].ovf   = 1'b1;
            vecs[41+j].udf   = (j >= 32);
            vecs[41+j].dout  = DW'((j < 32) ? j : 31);
        end

        wr = 0; rd = 0; flush = 0; clr_err = 0; in_data = '0;
        rst_n = 1'b0;
        #1;
        chk("reset_state", pack_std(), {12'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            wr      = vecs[k].wr;
            rd      = vecs[k].rd;
            in_data = vecs[k].din;
            step();
            chk($sformatf("vec%0d", k), pack_std(),
                {12'd0, vecs[k].cnt, vecs[k].full, vecs[k].empty, vecs[k].af,
                 vecs[k].ae, vecs[k].ovf, vecs[k].udf, vecs[k].dout});
        end
        wr = 0; rd = 0;

        // FWFT: first word visible without a read.
        do_reset();
        wr = 1; in_data = 8'hA5;
        step();
        wr = 0;
        chk("fwft_empty_fall", 32'(f_empty), 32'd0);
        chk("fwft_data", 32'(f_out), 32'hA5);
        step();
        chk("fwft_data_hold", 32'(f_out), 32'hA5);
        chk("fwft_cnt_hold", 32'(f_cnt), 32'd1);
        rd = 1;
        step();
        rd = 0;
        chk("fwft_empty_after_ack", 32'(f_empty), 32'd1);
        chk("fwft_cnt_after_ack", 32'(f_cnt), 32'd0);

        // Wrap-around with rd held high across 51 writes.
        do_reset();
        rd = 1;
        for (int i = 0; i <= 50; i++) begin
            wr = 1; in_data = DW'(i);
            step();
            if (s_cnt > 1) chk($sformatf("wrap_cnt%0d", i), 32'(s_cnt), 32'd1);
            if (i > 0) chk($sformatf("wrap_data%0d", i), 32'(s_out), 32'(i - 1));
        end
        wr = 0;
        step();
        rd = 0;
        chk("wrap_last", 32'(s_out), 32'd50);
        chk("wrap_drained", 32'(s_cnt), 32'd0);
        chk("wrap_no_ovf", 32'(s_ovf), 32'd0);

        // Flush with concurrent wr and rd.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr = 1; in_data = DW'(8'h80 + i);
            step();
        end
        chk("flush_pre_cnt", 32'(s_cnt), 32'd10);
        flush = 1; wr = 1; rd = 1; in_data = 8'hFF;
        step();
        flush = 0; wr = 0; rd = 0;
        chk("flush_cnt", 32'(s_cnt), 32'd0);
        chk("flush_empty", 32'(s_empty), 32'd1);
        chk("flush_err", 32'({s_ovf, s_udf}), 32'd0);
        wr = 1; in_data = 8'h3C;
        step();
        wr = 0;
        chk("flush_fwft_next", 32'(f_out), 32'h3C);
        rd = 1;
        step();
        rd = 0;
        chk("flush_std_next", 32'(s_out), 32'h3C);
        chk("flush_cnt_end", 32'(s_cnt), 32'd0);

        // Error set vs clear priority, then async reset mid-write.
        do_reset();
        for (int i = 0; i < 33; i++) begin
            wr = 1; in_data = DW'(8'h40 + i);
            step();
        end
        chk("err_ovf_set", 32'(s_ovf), 32'd1);
        clr_err = 1; wr = 1;
        step();
        chk("err_set_wins", 32'(s_ovf), 32'd1);
        wr = 0;
        step();
        clr_err = 0;
        chk("err_cleared", 32'(s_ovf), 32'd0);
        rd = 1;
        step();
        rd = 0;
        chk("err_read", 32'(s_out), 32'h40);
        chk("err_read_cnt", 32'(s_cnt), 32'd31);
        wr = 1; in_data = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", pack_std(), {12'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        chk("async_reset_fwft", 32'({f_cnt, f_empty, f_full}), 32'({6'd0, 1'b1, 1'b0}));
        wr = 0;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
